// File: rtl/c432_key_loader.sv
// c432_key_loader: serial key receiver with CRC-8 check, retry lockout and held key bus for the locked c432 core.
module c432_key_loader #(
  parameter int KEY_W     = 21,
  parameter int CRC_W     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             key_bit_i,
  input  logic             key_bit_valid_i,
  output logic             key_ready_o,
  output logic [KEY_W-1:0] key_out_o,
  output logic             key_valid_o,
  output logic             busy_o,
  output logic             crc_err_o,
  output logic             lockout_o,
  output logic [2:0]       fail_cnt_o
);
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, DONE = 3'd3, LOCKOUT = 3'd4;
  localparam logic [4:0] KEY_N = 5'(KEY_W);
  localparam logic [4:0] FRAME_N = 5'(KEY_W + CRC_W);
  localparam logic [4:0] LAST_N = 5'(KEY_W + CRC_W - 1);
  localparam logic [2:0] RETRY_N = 3'(MAX_RETRY);
  localparam logic [CRC_W-1:0] POLY = CRC_W'(8'h07);

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] shadow_q, shadow_d, key_q, key_d;
  logic [CRC_W-1:0] crc_q, crc_d, rx_crc_q, rx_crc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [2:0]       fail_q, fail_d, fail_inc;
  logic             valid_q, valid_d, err_q, err_d, lock_q, lock_d, fb;

  assign fb = crc_q[CRC_W-1] ^ key_bit_i;
  assign fail_inc = fail_q + 3'd1;

  always_comb begin
    state_d = state_q;
    shadow_d = shadow_q;
    crc_d = crc_q;
    rx_crc_d = rx_crc_q;
    cnt_d = cnt_q;
    key_d = key_q;
    valid_d = valid_q;
    err_d = 1'b0;
    lock_d = lock_q;
    fail_d = fail_q;
    // clear outranks start and bit acceptance but never unlocks a lockout
    if (clear_i && state_q != LOCKOUT) begin
      state_d = IDLE;
      key_d = '0;
      valid_d = 1'b0;
      shadow_d = '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start_i) begin
          state_d = LOAD;
          key_d = '0;
          valid_d = 1'b0;
          cnt_d = '0;
          crc_d = '0;
        end
        LOAD: if (key_bit_valid_i) begin
          if (cnt_q < KEY_N) begin
            shadow_d = {shadow_q[KEY_W-2:0], key_bit_i};
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
          end else begin
            rx_crc_d = {rx_crc_q[CRC_W-2:0], key_bit_i};
          end
          cnt_d = cnt_q == FRAME_N ? cnt_q : cnt_q + 5'd1;
          state_d = cnt_q == LAST_N ? CHECK : LOAD;
        end
        CHECK: if (rx_crc_q == crc_q) begin
          key_d = shadow_q;
          valid_d = 1'b1;
          fail_d = '0;
          state_d = DONE;
        end else begin
          err_d = 1'b1;
          fail_d = fail_inc;
          lock_d = fail_inc == RETRY_N;
          state_d = fail_inc == RETRY_N ? LOCKOUT : IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shadow_q <= '0;
      crc_q <= '0;
      rx_crc_q <= '0;
      cnt_q <= '0;
      key_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      lock_q <= 1'b0;
      fail_q <= '0;
    end else begin
      state_q <= state_d;
      shadow_q <= shadow_d;
      crc_q <= crc_d;
      rx_crc_q <= rx_crc_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      valid_q <= valid_d;
      err_q <= err_d;
      lock_q <= lock_d;
      fail_q <= fail_d;
    end
  end

  assign key_ready_o = state_q == LOAD;
  assign busy_o = state_q == LOAD || state_q == CHECK;
  assign key_out_o = key_q;
  assign key_valid_o = valid_q;
  assign crc_err_o = err_q;
  assign lockout_o = lock_q;
  assign fail_cnt_o = fail_q;
endmodule

// File: tb/tb_c432_key_loader.sv
// tb_c432_key_loader: randomized frames checked against a polynomial-division CRC model and outcome model.
module tb_c432_key_loader;
  logic clk = 0, rst_n = 0, start = 0, clear = 0, key_bit = 0, key_bit_valid = 0;
  logic key_ready, key_valid, busy, crc_err, lockout;
  logic [20:0] key_out;
  logic [2:0] fail_cnt;
  int n_chk = 0, n_err = 0;
  logic [20:0] exp_key = '0;
  logic exp_valid = 0, exp_lock = 0;
  int exp_fail = 0;

  c432_key_loader dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .clear_i(clear), .key_bit_i(key_bit),
    .key_bit_valid_i(key_bit_valid), .key_ready_o(key_ready), .key_out_o(key_out),
    .key_valid_o(key_valid), .busy_o(busy), .crc_err_o(crc_err), .lockout_o(lockout),
    .fail_cnt_o(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // CRC as the remainder of (key * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] crc8(input logic [20:0] k);
    logic [28:0] r;
    r = {k, 8'h00};
    for (int i = 28; i >= 8; i--)
      if (r[i]) r = r ^ (29'h107 << (i - 8));
    return r[7:0];
  endfunction

  task automatic check_state(input string tag);
    check({tag, "_key"}, 32'(key_out), 32'(exp_key));
    check({tag, "_valid"}, 32'(key_valid), 32'(exp_valid));
    check({tag, "_fail"}, 32'(fail_cnt), 32'(exp_fail));
    check({tag, "_lock"}, 32'(lockout), 32'(exp_lock));
  endtask

  task automatic do_load(input logic [20:0] k, input bit flip, input int ngaps);
    logic [28:0] fr;
    int gap_at[29];
    bit rdy_all, rdy_any, exp_err;
    fr = {k, crc8(k) ^ (flip ? 8'(1 << $urandom_range(0, 7)) : 8'h00)};
    foreach (gap_at[i]) gap_at[i] = 0;
    for (int g = 0; g < ngaps; g++) gap_at[$urandom_range(0, 28)]++;
    start = 1;
    tick;
    start = 0;
    if (!exp_lock) begin
      exp_key = '0;
      exp_valid = 0;
    end
    check("start_key", 32'(key_out), 32'(exp_key));
    check("start_valid", 32'(key_valid), 32'(exp_valid));
    rdy_all = 1;
    rdy_any = 0;
    for (int i = 28; i >= 0; i--) begin
      for (int g = 0; g < gap_at[i]; g++) begin
        key_bit_valid = 0;
        key_bit = 1'($urandom);
        rdy_all &= key_ready;
        rdy_any |= key_ready;
        tick;
      end
      key_bit_valid = 1;
      key_bit = fr[i];
      rdy_all &= key_ready;
      rdy_any |= key_ready;
      tick;
    end
    key_bit_valid = 0;
    if (exp_lock) check("ready_locked", 32'(rdy_any), 0);
    else check("ready_load", 32'(rdy_all), 1);
    check("busy_check", 32'(busy), 32'(!exp_lock));
    check("ready_drop", 32'(key_ready), 0);
    check("valid_pre", 32'(key_valid), 32'(exp_valid));
    tick;
    exp_err = 0;
    if (!exp_lock) begin
      if (!flip) begin
        exp_key = k;
        exp_valid = 1;
        exp_fail = 0;
      end else begin
        exp_err = 1;
        exp_fail++;
        exp_lock = exp_fail == 3;
      end
    end
    check_state("post");
    check("crc_err", 32'(crc_err), 32'(exp_err));
    check("busy_post", 32'(busy), 0);
    tick;
    check("crc_err_end", 32'(crc_err), 0);
  endtask

  task automatic do_clear;
    clear = 1;
    tick;
    clear = 0;
    if (!exp_lock) begin
      exp_key = '0;
      exp_valid = 0;
    end
    check_state("clear");
  endtask

  task automatic do_reset;
    rst_n = 0;
    #1;
    exp_key = '0;
    exp_valid = 0;
    exp_fail = 0;
    exp_lock = 0;
    check_state("rst");
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(key_ready), 0);
    check("rst_err", 32'(crc_err), 0);
    @(negedge clk);
    rst_n = 1;
    tick;
  endtask

  initial begin
    do_reset;
    do_load(21'h0A5F3C, 0, 0);
    do_load(21'h0A5F3C, 0, 5);
    do_load(21'($urandom), 1, 0);
    check("idle_busy", 32'(busy), 0);
    do_load(21'($urandom), 0, 2);
    for (int n = 0; n < 3; n++) begin
      do_load(21'($urandom), 1, $urandom_range(0, 3));
      if (n < 2) do_clear;
    end
    check("locked", 32'(lockout), 1);
    do_load(21'h0A5F3C, 0, 0);
    do_clear;
    start = 1;
    clear = 1;
    tick;
    start = 0;
    clear = 0;
    check_state("lock_ignore");
    check("lock_busy", 32'(busy), 0);
    do_reset;
    do_load(21'h1FFFFF, 0, 0);
    do_load(21'h000001, 0, 1);
    do_load(21'($urandom), 1, 0);
    start = 1;
    tick;
    start = 0;
    exp_key = '0;
    exp_valid = 0;
    for (int i = 0; i < 10; i++) begin
      key_bit_valid = 1;
      key_bit = 1'($urandom);
      tick;
    end
    key_bit_valid = 0;
    do_reset;
    do_load(21'h15A5A5, 0, 0);
    start = 1;
    clear = 1;
    tick;
    start = 0;
    clear = 0;
    exp_key = '0;
    exp_valid = 0;
    check_state("clr_start");
    check("clr_start_busy", 32'(busy), 0);
    tick;
    check("clr_start_busy2", 32'(busy), 0);
    for (int n = 0; n < 20; n++) begin
      do_load(21'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 4));
      if ($urandom_range(0, 4) == 0) do_clear;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
